// File: rtl/multicore_pkg.sv
// ============================================================================
// Module   : multicore_pkg
// Purpose  : Shared command/state encodings and default widths for the
//            multicore system controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicore_pkg;

  localparam int DEF_CORE_COUNT     = 3;
  localparam int DEF_MEM_WIDTH      = 12;
  localparam int DEF_INS_WIDTH      = 8;
  localparam int DEF_DATA_MEM_DEPTH = 2048;
  localparam int DEF_INS_MEM_DEPTH  = 256;
  localparam int DEF_TIMEOUT_CYCLES = 65536;
  localparam int COUNT_WIDTH        = 32;

  typedef enum logic [1:0] {
    CMD_WR_INS  = 2'd0,
    CMD_WR_DATA = 2'd1,
    CMD_RD_DATA = 2'd2,
    CMD_START   = 2'd3
  } hostCmd_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } ctrlState_t;

endpackage

`default_nettype wire

// File: rtl/run_watchdog.sv
// ============================================================================
// Module   : run_watchdog
// Purpose  : Saturating run-cycle counter with a programmable expiry limit
//            (limit of zero never expires).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module run_watchdog
  import multicore_pkg::*;
#(
  parameter int WIDTH = COUNT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != '1)) begin
      r_count <= r_count + C_ONE;
    end
  end

  // Fires during the last permitted cycle so the state change lands exactly at the limit.
  assign expired = (limit != '0) && (r_count == (limit - C_ONE));
  assign count   = r_count;

endmodule

`default_nettype wire

// File: rtl/multicore_system_ctrl.sv
// ============================================================================
// Module   : multicore_system_ctrl
// Purpose  : Host command front-end and run sequencer for a multicore
//            processor: loads instruction/data memories, starts runs and
//            watches them with a cycle watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicore_system_ctrl
  import multicore_pkg::*;
#(
  parameter int CORE_COUNT     = DEF_CORE_COUNT,
  parameter int MEM_WIDTH      = DEF_MEM_WIDTH,
  parameter int INS_WIDTH      = DEF_INS_WIDTH,
  parameter int DATA_MEM_DEPTH = DEF_DATA_MEM_DEPTH,
  parameter int INS_MEM_DEPTH  = DEF_INS_MEM_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int DW       = MEM_WIDTH * CORE_COUNT,
  localparam int MEM_ADDR = $clog2(DATA_MEM_DEPTH),
  localparam int INS_ADDR = $clog2(INS_MEM_DEPTH)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                host_valid,
  output logic                host_ready,
  input  logic [1:0]          host_cmd,
  input  logic [MEM_ADDR-1:0] host_addr,
  input  logic [DW-1:0]       host_wdata,
  output logic                rd_valid,
  output logic [DW-1:0]       rd_data,
  output logic                proc_start,
  input  logic                proc_done,
  input  logic [INS_ADDR-1:0] proc_ins_addr,
  input  logic [MEM_ADDR-1:0] proc_mem_addr,
  input  logic                proc_mem_we,
  input  logic [DW-1:0]       proc_wdata,
  output logic [INS_ADDR-1:0] im_addr,
  output logic                im_we,
  output logic [INS_WIDTH-1:0] im_wdata,
  output logic [MEM_ADDR-1:0] dm_addr,
  output logic                dm_we,
  output logic [DW-1:0]       dm_wdata,
  input  logic [DW-1:0]       dm_rdata,
  output logic                run_done,
  output logic                run_timeout,
  output logic [31:0]         cycle_count
);

  localparam logic [COUNT_WIDTH-1:0] C_LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES);

  ctrlState_t          r_state;
  ctrlState_t          w_nextState;
  logic                w_inRun;
  logic                w_accept;
  logic                w_startAccept;
  logic                w_expired;
  logic [COUNT_WIDTH-1:0] w_count;

  logic                r_cmdValid;
  hostCmd_t            r_cmd;
  logic [MEM_ADDR-1:0] r_addr;
  logic [DW-1:0]       r_wdata;
  logic                r_rdPending;
  logic                r_procStart;
  logic                r_runDone;
  logic                r_runTimeout;

  assign w_inRun       = (r_state == ST_RUN);
  assign w_accept      = host_valid && !w_inRun;
  assign w_startAccept = w_accept && (hostCmd_t'(host_cmd) == CMD_START);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_RUN: begin
        if (proc_done) begin
          w_nextState = ST_DONE;
        end else if (w_expired) begin
          w_nextState = ST_TIMEOUT;
        end
      end
      default: begin
        if (w_startAccept) begin
          w_nextState = ST_RUN;
        end
      end
    endcase
  end

  // One-deep host stage: memory ports are driven the cycle after acceptance.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cmdValid   <= 1'b0;
      r_cmd        <= CMD_WR_INS;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdPending  <= 1'b0;
      r_procStart  <= 1'b0;
      r_runDone    <= 1'b0;
      r_runTimeout <= 1'b0;
    end else begin
      r_cmdValid  <= w_accept && !w_startAccept;
      if (w_accept) begin
        r_cmd   <= hostCmd_t'(host_cmd);
        r_addr  <= host_addr;
        r_wdata <= host_wdata;
      end
      r_rdPending <= r_cmdValid && (r_cmd == CMD_RD_DATA);
      r_procStart <= w_startAccept;
      if (w_startAccept) begin
        r_runDone    <= 1'b0;
        r_runTimeout <= 1'b0;
      end else if (w_inRun) begin
        if (proc_done) begin
          r_runDone <= 1'b1;
        end else if (w_expired) begin
          r_runTimeout <= 1'b1;
        end
      end
    end
  end

  // The host stage can never hold a command while running: START is exclusive.
  always_comb begin
    im_addr  = '0;
    im_we    = 1'b0;
    im_wdata = '0;
    dm_addr  = '0;
    dm_we    = 1'b0;
    dm_wdata = '0;
    if (w_inRun) begin
      im_addr  = proc_ins_addr;
      dm_addr  = proc_mem_addr;
      dm_we    = proc_mem_we;
      dm_wdata = proc_wdata;
    end else if (r_cmdValid) begin
      case (r_cmd)
        CMD_WR_INS: begin
          im_addr  = r_addr[INS_ADDR-1:0];
          im_we    = 1'b1;
          im_wdata = r_wdata[INS_WIDTH-1:0];
        end
        CMD_WR_DATA: begin
          dm_addr  = r_addr;
          dm_we    = 1'b1;
          dm_wdata = r_wdata;
        end
        CMD_RD_DATA: begin
          dm_addr = r_addr;
        end
        default: ;
      endcase
    end
  end

  run_watchdog #(
    .WIDTH (COUNT_WIDTH)
  ) u_watchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (w_startAccept),
    .enable  (w_inRun),
    .limit   (C_LIMIT),
    .expired (w_expired),
    .count   (w_count)
  );

  assign host_ready  = !w_inRun;
  assign rd_valid    = r_rdPending;
  assign rd_data     = r_rdPending ? dm_rdata : '0;
  assign proc_start  = r_procStart;
  assign run_done    = r_runDone;
  assign run_timeout = r_runTimeout;
  assign cycle_count = w_count;

endmodule

`default_nettype wire

// File: tb/tb_multicore_system_ctrl.sv
// ============================================================================
// Module   : tb_multicore_system_ctrl
// Purpose  : Self-checking bench: host load/readback through a data memory
//            model with a read scoreboard, run/done, watchdog and reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicore_system_ctrl;

  localparam int DW       = 36;
  localparam int MEM_ADDR = 11;
  localparam int INS_ADDR = 8;

  logic                clock;
  logic                reset_n;
  logic                host_valid;
  logic                host_ready;
  logic [1:0]          host_cmd;
  logic [MEM_ADDR-1:0] host_addr;
  logic [DW-1:0]       host_wdata;
  logic                rd_valid;
  logic [DW-1:0]       rd_data;
  logic                proc_start;
  logic                proc_done;
  logic [INS_ADDR-1:0] proc_ins_addr;
  logic [MEM_ADDR-1:0] proc_mem_addr;
  logic                proc_mem_we;
  logic [DW-1:0]       proc_wdata;
  logic [INS_ADDR-1:0] im_addr;
  logic                im_we;
  logic [7:0]          im_wdata;
  logic [MEM_ADDR-1:0] dm_addr;
  logic                dm_we;
  logic [DW-1:0]       dm_wdata;
  logic [DW-1:0]       dm_rdata;
  logic                run_done;
  logic                run_timeout;
  logic [31:0]         cycle_count;

  // Second instance with a short watchdog limit
  logic                hostValidB;
  logic                hostReadyB;
  logic                procDoneB;
  logic                rdValidB;
  logic [DW-1:0]       rdDataB;
  logic                procStartB;
  logic [INS_ADDR-1:0] imAddrB;
  logic                imWeB;
  logic [7:0]          imWdataB;
  logic [MEM_ADDR-1:0] dmAddrB;
  logic                dmWeB;
  logic [DW-1:0]       dmWdataB;
  logic [DW-1:0]       dmRdataB;
  logic                runDoneB;
  logic                runTimeoutB;
  logic [31:0]         cycleCountB;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] mem   [0:2047];
  logic [DW-1:0] model [0:2047];
  logic [DW-1:0] expData[$];
  int            expCyc[$];
  logic [DW-1:0] monData;
  int            monCyc;

  multicore_system_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .host_valid(host_valid), .host_ready(host_ready), .host_cmd(host_cmd),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .proc_start(proc_start), .proc_done(proc_done),
    .proc_ins_addr(proc_ins_addr), .proc_mem_addr(proc_mem_addr),
    .proc_mem_we(proc_mem_we), .proc_wdata(proc_wdata),
    .im_addr(im_addr), .im_we(im_we), .im_wdata(im_wdata),
    .dm_addr(dm_addr), .dm_we(dm_we), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .run_done(run_done), .run_timeout(run_timeout), .cycle_count(cycle_count)
  );

  multicore_system_ctrl #(.TIMEOUT_CYCLES(16)) dutB (
    .clock(clock), .reset_n(reset_n),
    .host_valid(hostValidB), .host_ready(hostReadyB), .host_cmd(host_cmd),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .rd_valid(rdValidB), .rd_data(rdDataB),
    .proc_start(procStartB), .proc_done(procDoneB),
    .proc_ins_addr(proc_ins_addr), .proc_mem_addr(proc_mem_addr),
    .proc_mem_we(proc_mem_we), .proc_wdata(proc_wdata),
    .im_addr(imAddrB), .im_we(imWeB), .im_wdata(imWdataB),
    .dm_addr(dmAddrB), .dm_we(dmWeB), .dm_wdata(dmWdataB), .dm_rdata(dmRdataB),
    .run_done(runDoneB), .run_timeout(runTimeoutB), .cycle_count(cycleCountB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (dm_we) mem[dm_addr] <= dm_wdata;
    dm_rdata <= mem[dm_addr];
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read scoreboard: data and arrival cycle of every read
  always @(negedge clock) begin
    if (rd_valid) begin
      if (expData.size() == 0) begin
        checkVal("rd_unexpected", 1, 0);
      end else begin
        monData = expData.pop_front();
        monCyc  = expCyc.pop_front();
        checkVal("rd_data", rd_data, monData);
        checkVal("rd_cycle", cyc, monCyc);
      end
    end else begin
      checkVal("rd_idle_zero", rd_data, 0);
    end
  end

  task automatic issue(input logic [1:0] cmd, input logic [MEM_ADDR-1:0] addr, input logic [DW-1:0] data);
    @(posedge clock); #1;
    host_valid = 1'b1;
    host_cmd   = cmd;
    host_addr  = addr;
    host_wdata = data;
    if (cmd == 2'd1) model[addr] = data;
    if (cmd == 2'd2) begin
      expData.push_back(model[addr]);
      expCyc.push_back(cyc + 2);
    end
  endtask

  task automatic idle();
    @(posedge clock); #1;
    host_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; host_valid = 1'b0; host_cmd = '0; host_addr = '0; host_wdata = '0;
    proc_done = 1'b0; proc_ins_addr = '0; proc_mem_addr = '0; proc_mem_we = 1'b0;
    proc_wdata = '0; hostValidB = 1'b0; procDoneB = 1'b0; dmRdataB = '0;
    #23;
    checkVal("rst_host_ready", host_ready, 1);
    checkVal("rst_strobes", {proc_start, rd_valid, im_we, dm_we, run_done, run_timeout}, 0);
    checkVal("rst_cycle_count", cycle_count, 0);
    checkVal("rst_mem_addr", {im_addr, dm_addr}, 0);
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    checkVal("post_rst_ready", host_ready, 1);

    // Instruction write: upper address/data bits ignored
    issue(2'd0, 11'h705, 36'hF_FFFF_FFA7);
    @(negedge clock);
    checkVal("wrins_n_we", im_we, 0);
    idle();
    @(negedge clock);
    checkVal("wrins_we", im_we, 1);
    checkVal("wrins_addr", im_addr, 5);
    checkVal("wrins_data", im_wdata, 8'hA7);
    checkVal("wrins_dm_we", dm_we, 0);
    @(negedge clock);
    checkVal("wrins_we_drop", {im_we, im_addr}, 0);

    // Write then read the same address back-to-back
    issue(2'd1, 11'd10, 36'h1_2345_6789);
    issue(2'd2, 11'd10, 36'h0);
    @(negedge clock);
    checkVal("wrdata_we", dm_we, 1);
    checkVal("wrdata_addr", dm_addr, 10);
    checkVal("wrdata_data", dm_wdata, 36'h1_2345_6789);
    idle();
    @(negedge clock);
    checkVal("rd_port_we", dm_we, 0);
    checkVal("rd_port_addr", dm_addr, 10);

    // Burst of writes, reversed burst of reads, then interleaved overwrite
    for (int i = 0; i < 8; i++) issue(2'd1, 11'(100 + i), {4'($urandom), 32'($urandom)});
    for (int i = 7; i >= 0; i--) issue(2'd2, 11'(100 + i), '0);
    issue(2'd1, 11'd200, 36'hA_AAAA_5555);
    issue(2'd2, 11'd200, '0);
    issue(2'd1, 11'd200, 36'h5_5555_AAAA);
    issue(2'd2, 11'd200, '0);
    idle();
    repeat (4) @(posedge clock);

    // Run with done after 40 cycles; host write during run is dropped
    proc_ins_addr = 8'd7; proc_mem_addr = 11'd33; proc_mem_we = 1'b1; proc_wdata = 36'h9_8765_4321;
    issue(2'd3, '0, '0);
    @(posedge clock); #1;
    host_valid = 1'b1; host_cmd = 2'd1; host_addr = 11'd10; host_wdata = 36'h0_0000_0BAD;
    @(negedge clock);
    checkVal("run_start_pulse", proc_start, 1);
    checkVal("run_ready", host_ready, 0);
    checkVal("run_dm", {dm_we, dm_addr, dm_wdata}, {1'b1, 11'd33, 36'h9_8765_4321});
    checkVal("run_im", {im_we, im_addr}, {1'b0, 8'd7});
    model[33] = 36'h9_8765_4321;
    @(posedge clock); #1 host_valid = 1'b0;
    @(negedge clock);
    checkVal("run_start_once", proc_start, 0);
    checkVal("run_count1", cycle_count, 1);
    repeat (38) @(posedge clock);
    #1 proc_done = 1'b1;
    @(posedge clock); #1 proc_done = 1'b0;
    @(negedge clock);
    checkVal("done_flag", {run_done, run_timeout}, 2'b10);
    checkVal("done_count", cycle_count, 40);
    checkVal("done_ready", host_ready, 1);
    checkVal("done_dm_we", dm_we, 0);
    @(posedge clock); #1 proc_done = 1'b1;
    @(posedge clock); #1 proc_done = 1'b0;
    @(negedge clock);
    checkVal("done_hold", {run_done, host_ready, cycle_count}, {1'b1, 1'b1, 32'd40});

    // Watchdog expiry on the 16-cycle instance
    @(posedge clock); #1 hostValidB = 1'b1; host_cmd = 2'd3;
    @(posedge clock); #1 hostValidB = 1'b0;
    repeat (15) @(posedge clock);
    @(negedge clock);
    checkVal("wd_pre_ready", hostReadyB, 0);
    checkVal("wd_pre_count", cycleCountB, 15);
    checkVal("wd_pre_flag", runTimeoutB, 0);
    @(negedge clock);
    checkVal("wd_flags", {runDoneB, runTimeoutB}, 2'b01);
    checkVal("wd_count", cycleCountB, 16);
    checkVal("wd_ready", hostReadyB, 1);
    checkVal("wd_dm_we", dmWeB, 0);

    // Done on the limit cycle wins over the watchdog
    @(posedge clock); #1 hostValidB = 1'b1;
    @(posedge clock); #1 hostValidB = 1'b0;
    repeat (15) @(posedge clock);
    #1 procDoneB = 1'b1;
    @(posedge clock); #1 procDoneB = 1'b0;
    @(negedge clock);
    checkVal("lim_flags", {runDoneB, runTimeoutB}, 2'b10);
    checkVal("lim_count", cycleCountB, 16);

    // Readback: addr 10 keeps its pre-run value, 33 holds the processor write
    proc_mem_we = 1'b0;
    issue(2'd2, 11'd10, '0);
    issue(2'd2, 11'd33, '0);
    idle();
    repeat (4) @(posedge clock);
    checkVal("sb_empty", expData.size(), 0);

    // Reset mid-run
    issue(2'd3, '0, '0);
    idle();
    proc_mem_we = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    checkVal("mid_run_busy", {host_ready, dm_we}, 2'b01);
    reset_n = 1'b0;
    #1;
    checkVal("mrst_ready", host_ready, 1);
    checkVal("mrst_strobes", {proc_start, rd_valid, im_we, dm_we, run_done, run_timeout}, 0);
    checkVal("mrst_count", cycle_count, 0);
    @(posedge clock); #1 reset_n = 1'b1;
    proc_mem_we = 1'b0;
    @(negedge clock);
    checkVal("mrst_after", {host_ready, dm_we}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicore_system_ctrl.md
MULTICORE_SYSTEM_CTRL -- requirements
Module: multicore_system_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  CORE_COUNT  3  cores; data word DW = MEM_WIDTH*CORE_COUNT
  MEM_WIDTH  12  per-core data width
  INS_WIDTH  8  instruction width
  DATA_MEM_DEPTH  2048  MEM_ADDR = clog2(DATA_MEM_DEPTH)
  INS_MEM_DEPTH  256  INS_ADDR = clog2(INS_MEM_DEPTH)
  TIMEOUT_CYCLES  65536  RUN watchdog limit; 0 disables
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clock  in  1  single clock, rising edge
  reset_n  in  1  asynchronous, active-low reset
  host_valid  in  1  host command valid
  host_ready  out  1  command accepted when valid&&ready
  host_cmd  in  2  0 WR_INS, 1 WR_DATA, 2 RD_DATA, 3 START
  host_addr  in  MEM_ADDR  target address
  host_wdata  in  DW  write data
  rd_valid  out  1  read data valid
  rd_data  out  DW  read data
  proc_start  out  1  processor start pulse
  proc_done  in  1  processor finished
  proc_ins_addr  in  INS_ADDR  processor instruction address
  proc_mem_addr  in  MEM_ADDR  processor data address
  proc_mem_we  in  1  processor data write enable
  proc_wdata  in  DW  processor write data
  im_addr  out  INS_ADDR  instruction memory address
  im_we  out  1  instruction memory write enable
  im_wdata  out  INS_WIDTH  instruction memory write data
  dm_addr  out  MEM_ADDR  data memory address
  dm_we  out  1  data memory write enable
  dm_wdata  out  DW  data memory write data
  dm_rdata  in  DW  data memory read data, 1-cycle synchronous
  run_done  out  1  last run completed
  run_timeout  out  1  last run hit watchdog
  cycle_count  out  32  RUN cycles of current/last run

Function
REQ-003 States SHALL be IDLE, RUN, DONE, TIMEOUT; host_ready=1 in IDLE/DONE/TIMEOUT, 0 in RUN.
REQ-004 Accepted host command in cycle N SHALL be registered; memory port driven in N+1 from registered addr/data, we pulsed exactly one cycle.
REQ-005 WR_INS SHALL drive im_addr=host_addr[INS_ADDR-1:0], im_wdata=host_wdata[INS_WIDTH-1:0]; upper bits ignored.
REQ-006 WR_DATA SHALL drive dm_addr/dm_wdata, dm_we=1; RD_DATA drives dm_addr, dm_we=0.
REQ-007 RD_DATA accepted in N SHALL give rd_valid=1 in N+2 only, rd_data=dm_rdata (pass-through); rd_data=0 otherwise.
REQ-008 Back-to-back commands SHALL sustain one per cycle; reads/writes complete in accept order.
REQ-009 START accepted in N SHALL clear cycle_count, run_done, run_timeout; enter RUN at N+1; proc_start=1 in N+1 only.
REQ-010 In RUN, im_addr=proc_ins_addr, dm_addr=proc_mem_addr, dm_we=proc_mem_we, dm_wdata=proc_wdata, im_we=0; elsewhere, undriven memory outputs SHALL be 0.
REQ-011 In RUN cycle_count SHALL increment each cycle, saturating at all-ones.
REQ-012 proc_done in RUN SHALL enter DONE next cycle, run_done=1; cycle_count holds.
REQ-013 If TIMEOUT_CYCLES>0 and cycle_count==TIMEOUT_CYCLES-1 without proc_done, SHALL enter TIMEOUT, run_timeout=1; same-cycle proc_done wins (DONE).
REQ-014 proc_done outside RUN SHALL be ignored; host_valid in RUN SHALL be ignored (not queued).
REQ-015 DONE/TIMEOUT SHALL accept all commands (readback, reload, restart).

Reset
REQ-016 reset_n low SHALL immediately force IDLE; clear cycle_count, run_done, run_timeout, proc_start, rd_valid, im_we, dm_we and pending host stage; in-flight write dropped; host_ready=1 after release.

Structure
REQ-017 Command encodings, state encodings and default widths SHALL live in shared package multicore_pkg.
REQ-018 Watchdog/cycle counter SHALL be sub-module run_watchdog (clear, enable, limit, expired, count).

Verification
REQ-019 WR_INS addr 5 data 0xA7 -> im_we=1 one cycle at N+1, im_addr=5, im_wdata=0xA7.
REQ-020 WR_DATA addr 10 then RD_DATA addr 10 back-to-back -> rd_valid at read N+2, rd_data = written word.
REQ-021 START, proc_done asserted 40 cycles later -> proc_start one pulse, run_done=1, cycle_count=40, host_ready=1 again.
REQ-022 TIMEOUT_CYCLES=16, no proc_done -> TIMEOUT after 16 RUN cycles, run_timeout=1, dm_we=0 afterwards.
REQ-023 proc_done on limit cycle -> DONE, run_timeout=0; reset_n low mid-RUN -> IDLE, all strobes 0, cycle_count=0.
